// File: rtl/ni_sequencer.sv
// Next-instruction dispatch sequencer: arbitrates traps, halt and interrupts on a
// microcode NI request, otherwise runs the instruction-fetch handshake with a timeout.
module ni_sequencer #(
   parameter int TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       niREQ,
   input  logic       consTRAPEN,
   input  logic       flagTRAPEN,
   input  logic       flagTRAP1,
   input  logic       flagTRAP2,
   input  logic       cpuRUN,
   input  logic       intrREQ,
   input  logic       memACK,
   input  logic       nxmCLR,
   output logic       fetchREQ,
   output logic [3:0] dispNI,
   output logic       dispVALID,
   output logic       trapCLR,
   output logic       nxmERR,
   output logic       busy
);

   // state | meaning
   // IDLE  | waiting for niREQ; request flags sampled on entry to EVAL
   // EVAL  | one-cycle priority decode of sampled trap/halt/interrupt
   // FETCH | fetchREQ held, waiting for memACK or timeout
   // DONE  | dispVALID strobe, dispNI valid
   typedef enum logic [1:0] {IDLE, EVAL, FETCH, DONE} state_t;

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

   state_t state, stateNext;
   logic [CW-1:0] cnt, cntNext;
   logic en, t2, t1, run, intr;
   logic enNext, t2Next, t1Next, runNext, intrNext;
   logic fetchReqNext, dispValidNext, trapClrNext, nxmErrNext;
   logic [3:0] dispNiNext;
   logic [2:0] evalCode;
   logic evalTrap, evalDispatch;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         en        <= 1'b0;
         t2        <= 1'b0;
         t1        <= 1'b0;
         run       <= 1'b0;
         intr      <= 1'b0;
         fetchREQ  <= 1'b0;
         dispNI    <= 4'b0000;
         dispVALID <= 1'b0;
         trapCLR   <= 1'b0;
         nxmERR    <= 1'b0;
      end else begin
         state     <= stateNext;
         cnt       <= cntNext;
         en        <= enNext;
         t2        <= t2Next;
         t1        <= t1Next;
         run       <= runNext;
         intr      <= intrNext;
         fetchREQ  <= fetchReqNext;
         dispNI    <= dispNiNext;
         dispVALID <= dispValidNext;
         trapCLR   <= trapClrNext;
         nxmERR    <= nxmErrNext;
      end
   end

   always_comb begin
      evalCode     = 3'o0;
      evalTrap     = 1'b0;
      evalDispatch = 1'b1;
      if (en && t2 && t1) begin
         evalCode = 3'o1;
         evalTrap = 1'b1;
      end else if (en && t2) begin
         evalCode = 3'o2;
         evalTrap = 1'b1;
      end else if (en && t1) begin
         evalCode = 3'o3;
         evalTrap = 1'b1;
      end else if (!run) begin
         evalCode = 3'o5;
      end else if (intr) begin
         evalCode = 3'o6;
      end else begin
         evalDispatch = 1'b0;
      end
   end

   always_comb begin
      stateNext     = state;
      cntNext       = cnt;
      enNext        = en;
      t2Next        = t2;
      t1Next        = t1;
      runNext       = run;
      intrNext      = intr;
      fetchReqNext  = fetchREQ;
      dispNiNext    = dispNI;
      dispValidNext = 1'b0;
      trapClrNext   = 1'b0;
      nxmErrNext    = nxmERR & ~nxmCLR;
      case (state)
         IDLE: begin
            if (niREQ) begin
               enNext    = consTRAPEN & flagTRAPEN;
               t2Next    = flagTRAP2;
               t1Next    = flagTRAP1;
               runNext   = cpuRUN;
               intrNext  = intrREQ;
               stateNext = EVAL;
            end
         end
         EVAL: begin
            if (evalDispatch) begin
               dispNiNext    = {1'b0, evalCode};
               dispValidNext = 1'b1;
               trapClrNext   = evalTrap;
               stateNext     = DONE;
            end else begin
               cntNext      = '0;
               fetchReqNext = 1'b1;
               stateNext    = FETCH;
            end
         end
         FETCH: begin
            // ACK is checked first so an ACK on the terminal cycle is not an NXM
            if (memACK) begin
               dispNiNext    = 4'b1111;
               fetchReqNext  = 1'b0;
               dispValidNext = 1'b1;
               stateNext     = DONE;
            end else if (cnt == TC) begin
               dispNiNext    = 4'b0111;
               nxmErrNext    = 1'b1;
               fetchReqNext  = 1'b0;
               dispValidNext = 1'b1;
               stateNext     = DONE;
            end else begin
               cntNext = cnt + CW'(1);
            end
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: doc/ni_sequencer.md
Name: ni_sequencer

Overview:
- Sequences the next-instruction (NI) dispatch for the microcode.
- On each microcode NI request, arbitrates among pending traps, the halt condition and pending interrupts; otherwise it runs the instruction-fetch handshake with the memory interface.
- Registers the 4-bit NI dispatch code and presents it with a one-cycle valid strobe to the microsequencer dispatch mux.

Parameters:
- TIMEOUT, 64: cycles the fetch request may stay unacknowledged before a non-existent-memory error is declared (≥1).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- niREQ  input  1  one-cycle microcode request for NI dispatch
- consTRAPEN  input  1  console trap enable
- flagTRAPEN  input  1  APR trap enable flag
- flagTRAP1  input  1  PC flag TRAP1
- flagTRAP2  input  1  PC flag TRAP2
- cpuRUN  input  1  run flag
- intrREQ  input  1  interrupt pending (level)
- memACK  input  1  memory acknowledge for instruction fetch
- nxmCLR  input  1  clears sticky nxmERR
- fetchREQ  output  1  instruction fetch request
- dispNI  output  4  dispatch code [8:11]; bit 8 = fetch completed
- dispVALID  output  1  one-cycle strobe, dispNI valid
- trapCLR  output  1  one-cycle pulse: trap taken, clear TRAP1/TRAP2
- nxmERR  output  1  sticky fetch timeout error
- busy  output  1  sequencer not in IDLE

Behaviour:
- Reset values (async, immediate): state IDLE, fetchREQ 0, dispNI 4'b0000, dispVALID 0, trapCLR 0, nxmERR 0, busy 0, timeout counter 0.
- States: IDLE, EVAL, FETCH, DONE.
- IDLE:
  - On niREQ, register en = consTRAPEN & flagTRAPEN, t2 = flagTRAP2, t1 = flagTRAP1, run = cpuRUN, intr = intrREQ; go to EVAL.
  - memACK in IDLE is ignored.
- EVAL (exactly one cycle), priority on the sampled values:
  - en & t2 & t1: code 3'o1, trap 3.
  - en & t2 & ~t1: code 3'o2, trap 2.
  - en & ~t2 & t1: code 3'o3, trap 1.
  - ~run: code 3'o5, halt.
  - intr: code 3'o6, interrupt.
  - Otherwise: normal fetch.
  - Trap, halt and interrupt cases load dispNI = {0, code} and go to DONE. Trap cases also pulse trapCLR during the EVAL→DONE transition cycle (registered, high in the DONE cycle).
  - Normal fetch: clear the counter, set fetchREQ and go to FETCH.
- FETCH:
  - fetchREQ is held high.
  - memACK=1: dispNI = {1, 3'o7}, drop fetchREQ, go to DONE.
  - Otherwise the counter increments. After TIMEOUT cycles in FETCH without ACK: dispNI = {0, 3'o7}, set nxmERR, drop fetchREQ, go to DONE.
  - memACK in the same cycle as the timeout: ACK wins, nxmERR is not set.
- DONE: dispVALID=1 for exactly one cycle, then go to IDLE. dispNI holds its value until the next EVAL/FETCH update.
- busy=1 in EVAL, FETCH and DONE. niREQ while busy is ignored and not queued.
- Flag inputs are used only as sampled at niREQ; later changes do not affect the current dispatch.
- nxmERR: the set condition takes priority over nxmCLR in the same cycle. Otherwise nxmCLR clears it.
- Latency:
  - niREQ at cycle N: EVAL at N+1.
  - Trap, halt or interrupt: dispVALID and trapCLR at N+2.
  - Fetch: fetchREQ is first high at N+2. ACK sampled at cycle M gives dispVALID at M+1.
- Counter width: ceil(log2(TIMEOUT+1)). The counter saturates and never wraps.
- Reset asserted mid-FETCH drops fetchREQ asynchronously. No dispVALID is produced for the aborted request.

Test Plan:
- Trap 3: consTRAPEN=1, flagTRAPEN=1, TRAP2=1, TRAP1=1, pulse niREQ at cycle 0 → dispVALID and trapCLR at cycle 2, dispNI=4'b0001, fetchREQ never asserted. Repeat for TRAP2 only (4'b0010) and TRAP1 only (4'b0011). With consTRAPEN=0 and both flags set → normal fetch path.
- Halt: cpuRUN=0, intrREQ=1, no traps → dispNI=4'b0101 at cycle 2, no trapCLR. Halt outranks the interrupt.
- Interrupt: cpuRUN=1, intrREQ=1 → dispNI=4'b0110 at cycle 2.
- Normal fetch: cpuRUN=1, memACK returned at cycle 5 → fetchREQ high cycles 2–5, dispVALID at cycle 6 with dispNI=4'b1111, busy low at cycle 7.
- Timeout, TIMEOUT=4, no ACK:
  - fetchREQ high 4 cycles, then dispNI=4'b0111 and nxmERR=1 held.
  - ACK on the exact timeout cycle → dispNI=4'b1111, nxmERR=0.
  - nxmCLR clears nxmERR.
- Robustness:
  - niREQ re-pulsed during FETCH → ignored, single dispVALID.
  - Flags toggled after the niREQ sample → code unchanged.
  - rst mid-FETCH → fetchREQ=0 immediately, all outputs at reset values, no dispVALID.
